// File: rtl/switch_command_sequencer.sv
// Command sequencer for the MT8816 switch group; SEQ_TIMEOUT_EN adds a bounded rdy wait.
// Latency: sw_cs rises 2-3 cycles after a request, then at least 2 cycles after each sw_rdy rise.
// Backpressure: cmd_full when the FIFO is full (extra pushes dropped, err_ovf); sw_rdy paces every issue.

module seq_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push_vld,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop_rdy,
  output logic [W-1:0]  o_head_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_level == (AW+1)'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_push     = i_push_vld && !o_full;
  assign w_pop      = i_pop_rdy && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers are AW bits wide, so they wrap at DEPTH on their own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

module switch_command_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cmd_wr,
  input  logic [15:0]   i_cmd_data,
  output logic          o_cmd_full,
  output logic [AW:0]   o_cmd_level,
  input  logic          i_clear_req,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err_ovf,
  output logic          o_err_addr,
  output logic          o_err_tmo,
  input  logic          i_err_clr,
  output logic          o_sw_cs,
  output logic [3:0]    o_sw_op,
  output logic [15:0]   o_sw_data,
  input  logic          i_sw_rdy
);

  if (DEPTH != (1 << AW) || TIMEOUT < 2) begin : g_bad_cfg
    $error("switch_command_sequencer: DEPTH must equal 2**AW and TIMEOUT must be >= 2");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_CLR0, S_CLR1, S_POP, S_ISSUE, S_NEXT, S_WAIT_LO, S_WAIT_HI, S_ERROR
  } state_t;

  typedef enum logic [1:0] {R_CLR0, R_CLR1, R_CMD} ret_t;

  localparam logic [15:0] CMD_MASK = 16'h171F;

  state_t      r_state, w_state_nxt;
  ret_t        r_ret, w_ret_nxt;
  logic        r_from_start, w_from_start_nxt;
  logic        r_init_done, w_init_nxt;
  logic [15:0] r_word, w_word_nxt;
  logic        r_sw_cs, w_cs_nxt;
  logic [3:0]  r_sw_op, w_op_nxt;
  logic [15:0] r_sw_data, w_data_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err_ovf, r_err_addr;
  logic        w_pop, w_addr_set, w_tmo_hit;
  logic [15:0] w_head_dat;
  logic        w_full, w_empty;

  seq_fifo #(.W(16), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push_vld (i_cmd_wr),
    .i_push_dat (i_cmd_data),
    .i_pop_rdy  (w_pop),
    .o_head_dat (w_head_dat),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (o_cmd_level)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_ret_nxt        = r_ret;
    w_from_start_nxt = r_from_start;
    w_init_nxt       = r_init_done;
    w_word_nxt       = r_word;
    w_cs_nxt         = 1'b0;
    w_op_nxt         = r_sw_op;
    w_data_nxt       = r_sw_data;
    w_done_nxt       = 1'b0;
    w_pop            = 1'b0;
    w_addr_set       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_clear_req) begin
          w_state_nxt      = S_CLR0;
          w_from_start_nxt = 1'b0;
        end else if (i_start) begin
          if (!r_init_done) begin
            w_state_nxt      = S_CLR0;
            w_from_start_nxt = 1'b1;
          end else if (!w_empty) begin
            w_state_nxt = S_POP;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_CLR0: begin
        w_cs_nxt    = 1'b1;
        w_op_nxt    = 4'b0001;
        w_data_nxt  = 16'h0000;
        w_ret_nxt   = R_CLR0;
        w_state_nxt = S_WAIT_LO;
      end
      S_CLR1: begin
        w_cs_nxt    = 1'b1;
        w_op_nxt    = 4'b0001;
        w_data_nxt  = 16'h0010;
        w_ret_nxt   = R_CLR1;
        w_state_nxt = S_WAIT_LO;
      end
      S_POP: begin
        w_pop      = 1'b1;
        w_word_nxt = w_head_dat;
        if (w_head_dat[3:0] > 4'd13) begin
          w_addr_set  = 1'b1;
          w_state_nxt = S_NEXT;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cs_nxt    = 1'b1;
        w_op_nxt    = 4'b0010;
        w_data_nxt  = r_word & CMD_MASK;
        w_ret_nxt   = R_CMD;
        w_state_nxt = S_WAIT_LO;
      end
      // The strobe cycle itself is excluded so a stale rdy=0 cannot complete the handshake.
      S_WAIT_LO: begin
        if (!r_sw_cs && !i_sw_rdy) w_state_nxt = S_WAIT_HI;
        else if (w_tmo_hit)        w_state_nxt = S_ERROR;
      end
      S_WAIT_HI: begin
        if (i_sw_rdy) begin
          case (r_ret)
            R_CLR0: w_state_nxt = S_CLR1;
            R_CLR1: begin
              w_init_nxt = 1'b1;
              if (r_from_start && !w_empty) begin
                w_state_nxt = S_POP;
              end else begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
              end
            end
            default: w_state_nxt = S_NEXT;
          endcase
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_NEXT: begin
        if (!w_empty) begin
          w_state_nxt = S_POP;
        end else begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        if (i_err_clr) begin
          w_init_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_ret        <= R_CLR0;
      r_from_start <= 1'b0;
      r_init_done  <= 1'b0;
      r_word       <= '0;
      r_sw_cs      <= 1'b0;
      r_sw_op      <= '0;
      r_sw_data    <= '0;
      r_done       <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_addr   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ret        <= w_ret_nxt;
      r_from_start <= w_from_start_nxt;
      r_init_done  <= w_init_nxt;
      r_word       <= w_word_nxt;
      r_sw_cs      <= w_cs_nxt;
      r_sw_op      <= w_op_nxt;
      r_sw_data    <= w_data_nxt;
      r_done       <= w_done_nxt;
      if (i_cmd_wr && w_full) r_err_ovf <= 1'b1;
      else if (i_err_clr)     r_err_ovf <= 1'b0;
      if (w_addr_set)         r_err_addr <= 1'b1;
      else if (i_err_clr)     r_err_addr <= 1'b0;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_err_tmo;

  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
  assign o_err_tmo = r_err_tmo;

  // ERROR is only reachable through a timed-out wait.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
      r_err_tmo <= 1'b0;
    end else begin
      if (w_state_nxt != r_state)
        r_tmo_cnt <= '0;
      else if (r_state == S_WAIT_LO || r_state == S_WAIT_HI)
        r_tmo_cnt <= r_tmo_cnt + CW'(1);
      if (w_state_nxt == S_ERROR && r_state != S_ERROR) r_err_tmo <= 1'b1;
      else if (i_err_clr)                                r_err_tmo <= 1'b0;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign o_err_tmo = 1'b0;
`endif

  assign o_cmd_full = w_full;
  assign o_busy     = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign o_done     = r_done;
  assign o_err_ovf  = r_err_ovf;
  assign o_err_addr = r_err_addr;
  assign o_sw_cs    = r_sw_cs;
  assign o_sw_op    = r_sw_op;
  assign o_sw_data  = r_sw_data;

endmodule

// File: tb/tb_switch_command_sequencer.sv
// Directed bench for switch_command_sequencer: queue-based command model plus literal spot checks.
module tb_switch_command_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [15:0] cmd_data = '0;
  logic        clear_req = 1'b0;
  logic        start = 1'b0;
  logic        err_clr = 1'b0;
  logic        sw_rdy = 1'b1;
  logic        cmd_full, busy, done, err_ovf, err_addr, err_tmo, sw_cs;
  logic [4:0]  cmd_level;
  logic [3:0]  sw_op;
  logic [15:0] sw_data;

  switch_command_sequencer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_wr    (cmd_wr),
    .i_cmd_data  (cmd_data),
    .o_cmd_full  (cmd_full),
    .o_cmd_level (cmd_level),
    .i_clear_req (clear_req),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_err_ovf   (err_ovf),
    .o_err_addr  (err_addr),
    .o_err_tmo   (err_tmo),
    .i_err_clr   (err_clr),
    .o_sw_cs     (sw_cs),
    .o_sw_op     (sw_op),
    .o_sw_data   (sw_data),
    .i_sw_rdy    (sw_rdy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic        prev_cs = 1'b0;
  bit          stuck = 1'b0;
  logic [19:0] exp_q [$];
  logic [19:0] log_q [$];
  logic [15:0] m_fifo [$];
  bit          m_init = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_addr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: the expected issue stream derived directly from the command rules.
  function automatic logic [15:0] enable_word(input logic [15:0] w);
    logic [15:0] r;
    r = w;
    r[15:13] = 3'b000;
    r[11]    = 1'b0;
    r[7:5]   = 3'b000;
    return r;
  endfunction

  function automatic void model_clear();
    exp_q.push_back({4'b0001, 16'h0000});
    exp_q.push_back({4'b0001, 16'h0010});
    m_init = 1'b1;
  endfunction

  function automatic void model_start();
    logic [15:0] w;
    if (!m_init) model_clear();
    while (m_fifo.size() > 0) begin
      w = m_fifo.pop_front();
      if (w[3:0] > 4'd13) m_addr = 1'b1;
      else exp_q.push_back({4'b0010, enable_word(w)});
    end
  endfunction

  // Compare process: every strobe must match the head of the expected stream.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs = 1'b0;
    end else begin
      if (sw_cs) begin
        log_q.push_back({sw_op, sw_data});
        chk("cs_one_cycle", {31'b0, prev_cs}, 32'd0);
        chk("busy_during_issue", {31'b0, busy}, 32'd1);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_issue actual=%0h required=none", {sw_op, sw_data});
        end else begin
          chk("issue", {12'b0, sw_op, sw_data}, {12'b0, exp_q.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        chk("idle_at_done", {31'b0, busy}, 32'd0);
      end
      prev_cs = sw_cs;
    end
  end

  // Switch interface responder: rdy drops 2 cycles after cs, recovers 3 cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sw_cs && !stuck) begin
        repeat (2) @(posedge clk);
        #1 sw_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 sw_rdy = 1'b1;
      end
    end
  end

  task automatic push(input logic [15:0] w);
    @(negedge clk);
    cmd_wr   = 1'b1;
    cmd_data = w;
    if (m_fifo.size() < 16) m_fifo.push_back(w);
    else m_ovf = 1'b1;
    @(negedge clk);
    cmd_wr = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovf  = 1'b0;
    m_addr = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk(name, done_cnt - d0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_start(input string name);
    int d0;
    model_start();
    log_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(name, d0);
    chk({name, "_exp_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_flags(input string name);
    chk({name, "_level"}, {27'b0, cmd_level}, m_fifo.size());
    chk({name, "_ovf"}, {31'b0, err_ovf}, {31'b0, m_ovf});
    chk({name, "_addr"}, {31'b0, err_addr}, {31'b0, m_addr});
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_cs"}, {31'b0, sw_cs}, 32'd0);
    chk({name, "_op"}, {28'b0, sw_op}, 32'd0);
    chk({name, "_data"}, {16'b0, sw_data}, 32'd0);
    chk({name, "_busy"}, {31'b0, busy}, 32'd0);
    chk({name, "_done"}, {31'b0, done}, 32'd0);
    chk({name, "_level"}, {27'b0, cmd_level}, 32'd0);
    chk({name, "_full"}, {31'b0, cmd_full}, 32'd0);
    chk({name, "_errs"}, {29'b0, err_ovf, err_addr, err_tmo}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    logic [15:0] w;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Three commands, first start performs the chip clear.
    push(16'h1305);
    push(16'h0000);
    push(16'h020D);
    chk("t1_level3", {27'b0, cmd_level}, 32'd3);
    run_start("t1_done");
    chk("t1_issue_count", log_q.size(), 32'd5);
    if (log_q.size() == 5) begin
      chk("t1_clr0", {12'b0, log_q[0]}, {12'b0, 4'h1, 16'h0000});
      chk("t1_clr1", {12'b0, log_q[1]}, {12'b0, 4'h1, 16'h0010});
      chk("t1_cmd0", {12'b0, log_q[2]}, {12'b0, 4'h2, 16'h1305});
      chk("t1_cmd1", {12'b0, log_q[3]}, {12'b0, 4'h2, 16'h0000});
      chk("t1_cmd2", {12'b0, log_q[4]}, {12'b0, 4'h2, 16'h020D});
    end
    check_flags("t1");

    // Fill to 16, overflow with the 17th; junk bits must be stripped.
    for (int i = 0; i < 16; i++) begin
      w = 16'hE8E0 | 16'(i % 14) | (16'(i % 8) << 8);
      push(w);
    end
    chk("t2_full_before_ovf", {31'b0, cmd_full}, 32'd1);
    push(16'h0001);
    chk("t2_full", {31'b0, cmd_full}, 32'd1);
    chk("t2_level16", {27'b0, cmd_level}, 32'd16);
    chk("t2_ovf", {31'b0, err_ovf}, 32'd1);
    run_start("t2_done");
    chk("t2_issue_count", log_q.size(), 32'd16);
    if (log_q.size() == 16)
      chk("t2_cmd5_masked", {12'b0, log_q[5]}, {12'b0, 4'h2, 16'h0505});
    chk("t2_not_full", {31'b0, cmd_full}, 32'd0);
    check_flags("t2");
    pulse_err_clr();
    chk("t2_ovf_cleared", {31'b0, err_ovf}, 32'd0);

    // Out-of-range X is discarded.
    push(16'h000E);
    push(16'h0003);
    run_start("t3_done");
    chk("t3_addr", {31'b0, err_addr}, 32'd1);
    chk("t3_issue_count", log_q.size(), 32'd1);
    if (log_q.size() == 1)
      chk("t3_cmd", {12'b0, log_q[0]}, {12'b0, 4'h2, 16'h0003});
    check_flags("t3");
    pulse_err_clr();
    chk("t3_addr_cleared", {31'b0, err_addr}, 32'd0);

    // Start with an empty FIFO after init: immediate done, no issue.
    run_start("t3b_empty_done");
    chk("t3b_no_issue", log_q.size(), 32'd0);

`ifdef SEQ_TIMEOUT_EN
    // rdy never drops after an issue: 64-cycle timeout into ERROR.
    stuck = 1'b1;
    push(16'h0007);
    model_start();
    log_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!sw_cs && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_cs_seen", {31'b0, sw_cs}, 32'd1);
    n = 0;
    while (!err_tmo && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_tmo_cycles", n, 32'd64);
    chk("t5_err_tmo", {31'b0, err_tmo}, 32'd1);
    chk("t5_error_not_busy", {31'b0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("t5_error_no_cs", log_q.size(), 32'd1);
    stuck = 1'b0;
    pulse_err_clr();
    m_init = 1'b0;
    chk("t5_tmo_cleared", {31'b0, err_tmo}, 32'd0);
    run_start("t5_reclear_done");
    chk("t5_reclear_count", log_q.size(), 32'd2);
    if (log_q.size() == 2)
      chk("t5_reclear_clr1", {12'b0, log_q[1]}, {12'b0, 4'h1, 16'h0010});
`endif

    // clear_req and start together: clear only, FIFO left alone.
    push(16'h0101);
    push(16'h0202);
    model_clear();
    log_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    clear_req = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    start     = 1'b0;
    wait_done("t4_done", d0);
    chk("t4_exp_drained", exp_q.size(), 32'd0);
    chk("t4_issue_count", log_q.size(), 32'd2);
    chk("t4_level2", {27'b0, cmd_level}, 32'd2);
    check_flags("t4");

    // Reset during WAIT_HI with 5 words queued.
    push(16'h0303);
    push(16'h0404);
    push(16'h0505);
    chk("t6_level5", {27'b0, cmd_level}, 32'd5);
    model_start();
    log_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!sw_cs && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (sw_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_rdy_low_seen", {31'b0, sw_rdy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t6_abort");
    exp_q.delete();
    m_fifo.delete();
    m_init = 1'b0;
    m_ovf  = 1'b0;
    m_addr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // After reset, a start must clear again before the command.
    push(16'h0009);
    run_start("t7_done");
    chk("t7_issue_count", log_q.size(), 32'd3);
    if (log_q.size() == 3) begin
      chk("t7_clr0", {12'b0, log_q[0]}, {12'b0, 4'h1, 16'h0000});
      chk("t7_cmd", {12'b0, log_q[2]}, {12'b0, 4'h2, 16'h0009});
    end
    check_flags("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_command_sequencer.md
Name: switch_command_sequencer

Overview:
- Upstream stage for the MT8816 crosspoint switch interface group.
- Buffers host crosspoint commands in a FIFO and replays them one at a time over the cs/op/data_in/rdy handshake.
- Issues the per-chip reset commands needed before first use and on demand.
- Frees the host from cycle-level pacing of switch programming.

Parameters:
- DEPTH, 16, command FIFO depth in words (power of two, 2..256).
- AW, 4, FIFO address width, equal to log2(DEPTH).
- TIMEOUT, 64, max cycles spent in any wait-for-rdy state (only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_wr  in  1  push cmd_data into FIFO this cycle.
- cmd_data  in  16  command word: [3:0] X (0..13), [4] switch select, [10:8] Y, [12] DATA; other bits ignored.
- cmd_full  out  1  FIFO holds DEPTH words.
- cmd_level  out  AW+1  current FIFO occupancy.
- clear_req  in  1  one-cycle request: reset switch 0 then switch 1.
- start  in  1  one-cycle request: drain FIFO to the switches.
- busy  out  1  high in every state except IDLE and ERROR.
- done  out  1  one-cycle pulse when a drain or clear sequence completes.
- err_ovf  out  1  sticky: push attempted while full.
- err_addr  out  1  sticky: word with X>13 popped and discarded.
- err_tmo  out  1  sticky: rdy handshake timed out (SEQ_TIMEOUT_EN only, else tied 0).
- err_clr  in  1  clears all sticky errors and leaves ERROR state.
- sw_cs  out  1  one-cycle command strobe to the switch interface.
- sw_op  out  4  op[0]=reset, op[1]=enable, op[3:2]=0.
- sw_data  out  16  command word to the switch interface.
- sw_rdy  in  1  switch interface ready.

Behaviour:
- Reset (rst_n low, async): state IDLE; FIFO empty; cmd_level=0; sw_cs=0; sw_op=0; sw_data=0; busy=0; done=0; all err_*=0; init_done=0.
- FIFO push: cmd_wr with cmd_level<DEPTH stores the word; the write pointer wraps at DEPTH.
- Push while full: word dropped and err_ovf set.
- Pop with simultaneous push: allowed; cmd_level unchanged.
- All sw_* outputs are registered.
- Issue rule: sw_cs high for exactly one cycle; sw_op and sw_data are valid in that cycle and held until the next issue.
- Handshake: after each issue the block waits for sw_rdy=0 (WAIT_LO), then for sw_rdy=1 (WAIT_HI). sw_rdy is never sampled in the issue cycle. Downstream drops rdy 2 cycles after cs.
- States:
  - IDLE: clear_req, or start with init_done=0, goes to CLR0. Otherwise start with FIFO non-empty goes to POP. start with FIFO empty pulses done and stays IDLE. If clear_req and start arrive together, clear wins and start is discarded.
  - CLR0: issue op=4'b0001, data=16'h0000 (switch 0), then WAIT_LO/WAIT_HI, then CLR1.
  - CLR1: issue op=4'b0001, data=16'h0010 (switch 1), then WAIT_LO/WAIT_HI. Sets init_done=1. If the sequence was triggered by start, go to POP; otherwise pulse done and go to IDLE.
  - POP: read FIFO head and decrement level. X>13 sets err_addr, drops the word, and goes to NEXT. Otherwise go to ISSUE.
  - ISSUE: sw_op=4'b0010, sw_data=word with bits [15:13], [11], [7:5] forced to 0; then WAIT_LO and WAIT_HI.
  - NEXT: FIFO non-empty goes to POP; empty pulses done and goes to IDLE.
  - ERROR: sw_cs held 0; FIFO untouched. err_clr returns to IDLE with init_done=0.
- Requests while busy: clear_req and start ignored; cmd_wr still accepted.
- err_clr outside ERROR: clears sticky flags only.
- rst_n asserted mid-sequence: immediate abort to reset values; the partially issued command is not retried.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined: a counter runs in WAIT_LO/WAIT_HI and resets on each state entry. Reaching TIMEOUT cycles sets err_tmo and moves to ERROR.
- Not defined: no counter; waits are unbounded; err_tmo tied 0.

Test Plan:
- Reset, push 3 words (16'h1305, 16'h0000, 16'h020D), start → auto clear first (sw_cs with op=1, data=0000, then 0010), then 3 enable issues in FIFO order, each sw_cs one cycle and ≥2 cycles after rdy rises; then done pulse, cmd_level=0.
- Push 16 words then a 17th → cmd_full=1, err_ovf=1, only 16 issued after start.
- Push 16'h000E then 16'h0003, start (init_done=1) → err_addr=1; one issue only, data=0003.
- clear_req and start in the same cycle while IDLE → two reset issues, done pulse, no enable issues, FIFO level unchanged.
- With SEQ_TIMEOUT_EN and sw_rdy stuck 1 after an issue → after 64 cycles err_tmo=1 and ERROR state. err_clr returns to IDLE, and the next start re-runs the clear.
- Assert rst_n low during WAIT_HI with 5 words queued → all outputs at reset values within the same cycle, cmd_level=0.
